// File: rtl/count_ser_pkg.sv
`default_nettype none
// ============================================================================
// count_ser_pkg : shared constants and state encoding for the snapshot serializer
// Optional build macro: COUNT_SER_PARITY_EN.  Rev 1.0
// ============================================================================
package count_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int COUNT_WIDTH = 8;

`ifdef COUNT_SER_PARITY_EN
  localparam int FRAME_BITS = COUNT_WIDTH + 3;
`else
  localparam int FRAME_BITS = COUNT_WIDTH + 2;
`endif

  localparam logic SER_IDLE_LEVEL = 1'b1;

endpackage : count_ser_pkg
`default_nettype wire

// File: rtl/ser_bit_timer.sv
`default_nettype none
// ============================================================================
// ser_bit_timer : clk-per-bit down-counter; o_bit_tick marks the last cycle of a bit
// Rev 1.0
// ============================================================================
module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_tick
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Clear preloads the full bit period so the first bit is as long as the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= LOAD_VAL;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? LOAD_VAL : (r_cnt - CW'(1));
    end
  end

  assign o_bit_tick = i_en && (r_cnt == '0);

endmodule : ser_bit_timer
`default_nettype wire

// File: rtl/count_snapshot_serializer.sv
`default_nettype none
// ============================================================================
// count_snapshot_serializer : snapshots the counter and sends it as a UART-style
// frame (start 0, LSB first, optional even parity with COUNT_SER_PARITY_EN, stop 1).  Rev 1.0
// ============================================================================
module count_snapshot_serializer
  import count_ser_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_count_in,
  input  logic             i_snap_req,
  output logic             o_busy,
  output logic             o_ser_out,
  output logic             o_frame_done
);

  localparam int            BW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_busy;
  logic             r_ser;
  logic             r_done;
`ifdef COUNT_SER_PARITY_EN
  logic             r_parity;
`endif

  logic w_accept;
  logic w_tick;
  logic w_timer_en;

  assign w_accept   = i_enable && i_snap_req && (r_state == ST_IDLE);
  assign w_timer_en = i_enable && (r_state != ST_IDLE);

  ser_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_timer_en),
    .i_clr      (w_accept),
    .o_bit_tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_ser     <= SER_IDLE_LEVEL;
      r_done    <= 1'b0;
`ifdef COUNT_SER_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (!i_enable) begin
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_snap_req) begin
            r_shreg <= i_count_in;
`ifdef COUNT_SER_PARITY_EN
            r_parity <= ^i_count_in;
`endif
            r_state <= ST_START;
            r_busy  <= 1'b1;
            r_ser   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_ser     <= r_shreg[0];
          end
        end
        ST_DATA: begin
          // Next bit is presented from r_shreg[1] because the shift lands on the same edge.
          if (w_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
`ifdef COUNT_SER_PARITY_EN
              r_state <= ST_PARITY;
              r_ser   <= r_parity;
`else
              r_state <= ST_STOP;
              r_ser   <= SER_IDLE_LEVEL;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_shreg   <= r_shreg >> 1;
              r_ser     <= r_shreg[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_ser   <= SER_IDLE_LEVEL;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ser   <= SER_IDLE_LEVEL;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ser   <= SER_IDLE_LEVEL;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_ser_out    = r_ser;
  assign o_frame_done = r_done;

endmodule : count_snapshot_serializer
`default_nettype wire

// File: tb/tb_count_snapshot_serializer.sv
`default_nettype none
// ============================================================================
// tb_count_snapshot_serializer : directed checks of framing, pause, back-to-back,
// reset abort and one-cycle-per-bit operation.  Rev 1.0
// ============================================================================
module tb_count_snapshot_serializer;

  localparam int C = 4;
`ifdef COUNT_SER_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] cnt4, cnt1;
  logic       req4, req1;
  logic       busy4, ser4, done4;
  logic       busy1, ser1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_snapshot_serializer #(.WIDTH(8), .CLKS_PER_BIT(C)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (enable),
    .i_count_in   (cnt4),
    .i_snap_req   (req4),
    .o_busy       (busy4),
    .o_ser_out    (ser4),
    .o_frame_done (done4)
  );

  count_snapshot_serializer #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (enable),
    .i_count_in   (cnt1),
    .i_snap_req   (req1),
    .o_busy       (busy1),
    .o_ser_out    (ser1),
    .o_frame_done (done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit index idx (0 = start).
  function automatic logic frame_bit(input logic [7:0] v, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
`ifdef COUNT_SER_PARITY_EN
    if (idx == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  // Entered just after the capture edge; leaves just after the frame_done edge.
  task automatic check_frame(input string name, input logic [7:0] v,
                             input int pause_at, input int pause_len,
                             input int change_at, input logic [7:0] new_v);
    for (int k = 0; k < FB*C; k++) begin
      chk({name, "_ser"},  ser4,  frame_bit(v, k / C));
      chk({name, "_busy"}, busy4, 1'b1);
      chk({name, "_done"}, done4, 1'b0);
      if (k == change_at) cnt4 = new_v;
      if (k == pause_at) begin
        enable = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          tick();
          chk({name, "_hold_ser"},  ser4,  frame_bit(v, k / C));
          chk({name, "_hold_busy"}, busy4, 1'b1);
        end
        enable = 1'b1;
      end
      tick();
    end
    chk({name, "_end_done"}, done4, 1'b1);
    chk({name, "_end_busy"}, busy4, 1'b0);
    chk({name, "_end_ser"},  ser4,  1'b1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    cnt4 = 8'h00; cnt1 = 8'h00; req4 = 1'b0; req1 = 1'b0;
    #1;
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_ser4",  ser4,  1'b1);
    chk("rst_done4", done4, 1'b0);
    chk("rst_ser1",  ser1,  1'b1);
    tick();
    reset = 1'b0;
    tick();

    // Request while disabled must not start a frame.
    enable = 1'b0; req4 = 1'b1;
    tick(); tick();
    chk("dis_req_busy", busy4, 1'b0);
    chk("dis_req_ser",  ser4,  1'b1);
    req4 = 1'b0; enable = 1'b1;
    tick();

    // Basic frame of 8'hC5.
    cnt4 = 8'hC5; req4 = 1'b1;
    tick();
    req4 = 1'b0;
    check_frame("c5", 8'hC5, -1, 0, -1, 8'h00);
    tick();
    chk("c5_done_pulse", done4, 1'b0);

    // Frame of 8'h01 (parity 1 when the parity bit is present).
    cnt4 = 8'h01; req4 = 1'b1;
    tick();
    req4 = 1'b0;
    check_frame("h01", 8'h01, -1, 0, -1, 8'h00);
    tick();

    // Pause for 7 cycles mid-DATA.
    cnt4 = 8'hC5; req4 = 1'b1;
    tick();
    req4 = 1'b0;
    check_frame("pause", 8'hC5, 14, 7, -1, 8'h00);
    tick();

    // Held request: back-to-back frames, count changed mid-frame.
    cnt4 = 8'hA5; req4 = 1'b1;
    tick();
    check_frame("b2b_a", 8'hA5, -1, 0, 10, 8'h3C);
    tick();
    req4 = 1'b0;
    check_frame("b2b_b", 8'h3C, -1, 0, -1, 8'h00);
    tick();
    chk("b2b_idle_busy", busy4, 1'b0);

    // Reset abort during data bit 3.
    cnt4 = 8'h52; req4 = 1'b1;
    tick();
    req4 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      chk("abort_pre_ser", ser4, frame_bit(8'h52, k / C));
      tick();
    end
    chk("abort_bit3_ser", ser4, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_ser",  ser4,  1'b1);
    chk("abort_busy", busy4, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    chk("abort_no_done", done4, 1'b0);
    tick();
    chk("abort_no_done2", done4, 1'b0);
    chk("abort_idle_busy", busy4, 1'b0);
    cnt4 = 8'hB4; req4 = 1'b1;
    tick();
    req4 = 1'b0;
    check_frame("after_rst", 8'hB4, -1, 0, -1, 8'h00);
    tick();

    // One cycle per bit.
    cnt1 = 8'hFF; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    for (int k = 0; k < FB; k++) begin
      chk("cpb1_ser",  ser1,  frame_bit(8'hFF, k));
      chk("cpb1_busy", busy1, 1'b1);
      chk("cpb1_done", done1, 1'b0);
      tick();
    end
    chk("cpb1_end_done", done1, 1'b1);
    chk("cpb1_end_busy", busy1, 1'b0);
    tick();
    chk("cpb1_done_clr", done1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_count_snapshot_serializer
`default_nettype wire
